// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round functions for the compression core.
package sha256_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned RND_W      = 6;
  localparam int unsigned NUM_ROUNDS = 64;
  localparam int unsigned NUM_WORDS  = 8;
  localparam int unsigned WIN_DEPTH  = 16;
  localparam int unsigned HASH_W     = 256;
  localparam int unsigned BLOCK_W    = 512;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  localparam word_t IV_H0 = 32'h6a09e667;
  localparam word_t IV_H1 = 32'hbb67ae85;
  localparam word_t IV_H2 = 32'h3c6ef372;
  localparam word_t IV_H3 = 32'ha54ff53a;
  localparam word_t IV_H4 = 32'h510e527f;
  localparam word_t IV_H5 = 32'h9b05688c;
  localparam word_t IV_H6 = 32'h1f83d9ab;
  localparam word_t IV_H7 = 32'h5be0cd19;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_engine_krom.sv
// Combinational SHA-256 round-constant ROM, K[idx] for idx = 0..63.
module sha256_round_engine_krom
  import sha256_pkg::*;
(
  input  logic [RND_W-1:0] idx_i,
  output word_t            k_c_o
);

  localparam word_t K_TAB [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  assign k_c_o = K_TAB[idx_i];

endmodule

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression: one round per clock, 16-word rolling message
// schedule, final chaining add registered together with the done pulse.
module sha256_round_engine
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] block_in,
  input  logic [HASH_W-1:0]  hash_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [HASH_W-1:0]  hash_out
);

  state_e           state_q;
  logic [RND_W-1:0] t_q;
  word_t            h_q [NUM_WORDS];
  word_t            v_q [NUM_WORDS];
  word_t            w_q [WIN_DEPTH];

  word_t             k_c;
  word_t             t1_d;
  word_t             t2_d;
  word_t             w15_d;
  word_t             v_d [NUM_WORDS];
  logic [HASH_W-1:0] sum_d;

  sha256_round_engine_krom u_krom (
    .idx_i (t_q),
    .k_c_o (k_c)
  );

  // Round datapath: v_q[0..7] hold a..h, w_q[0] is W_t.
  always_comb begin
    t1_d   = v_q[7] + big_sigma1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + k_c + w_q[0];
    t2_d   = big_sigma0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
    v_d[0] = t1_d + t2_d;
    v_d[1] = v_q[0];
    v_d[2] = v_q[1];
    v_d[3] = v_q[2];
    v_d[4] = v_q[3] + t1_d;
    v_d[5] = v_q[4];
    v_d[6] = v_q[5];
    v_d[7] = v_q[6];
    w15_d  = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    sum_d  = {h_q[0] + v_d[0], h_q[1] + v_d[1], h_q[2] + v_d[2], h_q[3] + v_d[3],
              h_q[4] + v_d[4], h_q[5] + v_d[5], h_q[6] + v_d[6], h_q[7] + v_d[7]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      t_q      <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      hash_out <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        h_q[i] <= '0;
        v_q[i] <= '0;
      end
      for (int j = 0; j < WIN_DEPTH; j++) begin
        w_q[j] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_ROUND;
            ready   <= 1'b0;
            busy    <= 1'b1;
            t_q     <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
              h_q[i] <= hash_in[WORD_W*(NUM_WORDS-1-i) +: WORD_W];
              v_q[i] <= hash_in[WORD_W*(NUM_WORDS-1-i) +: WORD_W];
            end
            for (int j = 0; j < WIN_DEPTH; j++) begin
              w_q[j] <= block_in[WORD_W*(WIN_DEPTH-1-j) +: WORD_W];
            end
          end
        end
        ST_ROUND: begin
          for (int i = 0; i < NUM_WORDS; i++) begin
            v_q[i] <= v_d[i];
          end
          for (int j = 0; j < WIN_DEPTH - 1; j++) begin
            w_q[j] <= w_q[j+1];
          end
          w_q[WIN_DEPTH-1] <= w15_d;
          // Last round: publish the chained digest as FINAL is entered.
          if (t_q == RND_W'(NUM_ROUNDS - 1)) begin
            t_q      <= '0;
            state_q  <= ST_FINAL;
            hash_out <= sum_d;
            done     <= 1'b1;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        ST_FINAL: begin
          state_q <= ST_IDLE;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Scoreboard bench for sha256_round_engine: known digests, an independent
// reference model, busy rejection, input stability, mid-run reset and chaining.
module tb_sha256_round_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] block_in;
  logic [255:0] hash_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  sha256_round_engine dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .hash_in  (hash_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_2A    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B    = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  int           vectors     = 0;
  int           miscompares = 0;
  int           done_cnt    = 0;
  time          last_done_t = 0;
  time          prev_done_t = 0;
  string        cur_test    = "reset";
  logic [255:0] exp_q [$];
  time          acc_q [$];

  task automatic check_vec(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s/%s: got %h expected %h", cur_test, tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight-line FIPS 180-4 compression with a fully expanded schedule.
  function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hin);
    logic [31:0]  w [64];
    logic [31:0]  s [8];
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) s[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[i] + w[i];
      t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
      s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + s[i];
    return r;
  endfunction

  // Output side of the scoreboard.
  always @(negedge clk) begin
    logic [255:0] exp_v;
    time          acc_t;
    if (!rst && done) begin
      done_cnt++;
      prev_done_t = last_done_t;
      last_done_t = $time;
      if (exp_q.size() == 0) begin
        check_vec("unexpected_done", 256'(done), 256'd0);
      end else begin
        exp_v = exp_q.pop_front();
        acc_t = acc_q.pop_front();
        check_vec("digest", hash_out, exp_v);
        check_vec("latency", 256'(($time - acc_t + 5) / 10), 256'd65);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [511:0] blk, input logic [255:0] hin, input logic [255:0] exp_dig);
    check_vec("ready_at_start", 256'(ready), 256'd1);
    block_in = blk;
    hash_in  = hin;
    start    = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp_dig);
    acc_q.push_back($time);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = done_cnt;
    n    = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == base) check_vec("done_timeout", 256'd0, 256'd1);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom();
    return b;
  endfunction

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int k = 0; k < 8; k++) h[32*k +: 32] = $urandom();
    return h;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           base;
    logic [255:0] ref1;
    logic [255:0] ref2;
    logic [511:0] rb;
    logic [255:0] rh;

    rst      = 1'b1;
    start    = 1'b0;
    block_in = '0;
    hash_in  = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_vec("ready", 256'(ready), 256'd1);
    check_vec("busy", 256'(busy), 256'd0);
    check_vec("done", 256'(done), 256'd0);
    check_vec("hash_out", hash_out, 256'd0);

    cur_test = "abc";
    launch(BLK_ABC, IV, DIG_ABC);
    check_vec("ready_in_round", 256'(ready), 256'd0);
    check_vec("busy_in_round", 256'(busy), 256'd1);
    wait_done(80);
    check_vec("ready_after", 256'(ready), 256'd1);
    check_vec("busy_after", 256'(busy), 256'd0);
    check_vec("hash_held", hash_out, DIG_ABC);

    cur_test = "empty";
    launch(BLK_EMPTY, IV, DIG_EMPTY);
    wait_done(80);

    cur_test = "busy_reject";
    base = done_cnt;
    launch(BLK_ABC, IV, DIG_ABC);
    repeat (9) tick();
    start    = 1'b1;
    block_in = BLK_EMPTY;
    hash_in  = ~IV;
    tick();
    start = 1'b0;
    check_vec("ready_c11", 256'(ready), 256'd0);
    check_vec("busy_c11", 256'(busy), 256'd1);
    repeat (54) tick();
    check_vec("done_c65", 256'(done), 256'd1);
    check_vec("ready_c65", 256'(ready), 256'd0);
    start    = 1'b1;
    block_in = rand_block();
    tick();
    start = 1'b0;
    check_vec("ready_c66", 256'(ready), 256'd1);
    repeat (70) tick();
    check_vec("done_count", 256'(done_cnt - base), 256'd1);
    check_vec("hash_kept", hash_out, DIG_ABC);

    cur_test = "stability";
    base = done_cnt;
    launch(BLK_ABC, IV, DIG_ABC);
    for (int i = 0; i < 70; i++) begin
      block_in = rand_block();
      hash_in  = rand_hash();
      tick();
    end
    check_vec("done_count", 256'(done_cnt - base), 256'd1);

    cur_test = "mid_reset";
    base = done_cnt;
    launch(BLK_ABC, IV, DIG_ABC);
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    check_vec("ready", 256'(ready), 256'd1);
    check_vec("busy", 256'(busy), 256'd0);
    check_vec("done", 256'(done), 256'd0);
    check_vec("hash_out", hash_out, 256'd0);
    repeat (80) tick();
    check_vec("no_done", 256'(done_cnt - base), 256'd0);
    launch(BLK_ABC, IV, DIG_ABC);
    wait_done(80);

    cur_test = "random";
    for (int i = 0; i < 3; i++) begin
      rb = rand_block();
      rh = rand_hash();
      launch(rb, rh, ref_compress(rb, rh));
      wait_done(80);
    end

    cur_test = "chain";
    ref1 = ref_compress(BLK_2A, IV);
    ref2 = ref_compress(BLK_2B, ref1);
    launch(BLK_2A, IV, ref1);
    wait_done(80);
    launch(BLK_2B, hash_out, ref2);
    wait_done(80);
    check_vec("done_spacing", 256'((last_done_t - prev_done_t) / 10), 256'd66);
    check_vec("two_block_digest", hash_out, DIG_TWO);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
